// File: rtl/hazard_sched_if.sv
// hazard_sched_if: ID-stage operand/destination info in, pipeline hold/flush controls out
interface hazard_sched_if;
  logic        id_valid;
  logic [4:0]  id_rs_a;
  logic        id_rs_a_used;
  logic [4:0]  id_rs_b;
  logic        id_rs_b_used;
  logic        id_wr_en;
  logic [4:0]  id_wr_dir;
  logic        ex_redirect;
  logic        pc_hold;
  logic        ifd_hold;
  logic        ifd_flush;
  logic        de_bubble;
  logic [1:0]  state;
  logic [31:0] stall_cycles;
  modport master (
    output id_valid, id_rs_a, id_rs_a_used, id_rs_b, id_rs_b_used, id_wr_en, id_wr_dir, ex_redirect,
    input  pc_hold, ifd_hold, ifd_flush, de_bubble, state, stall_cycles
  );
  modport slave (
    input  id_valid, id_rs_a, id_rs_a_used, id_rs_b, id_rs_b_used, id_wr_en, id_wr_dir, ex_redirect,
    output pc_hold, ifd_hold, ifd_flush, de_bubble, state, stall_cycles
  );
endinterface

// File: rtl/hazard_sched.sv
// hazard_sched: countdown register scoreboard driving PC/PipeIFD holds, PipeDE bubbles and redirect flushes
module hazard_sched #(
  parameter int WB_LAT = 3
) (
  input logic clk,
  input logic rst,
  hazard_sched_if.slave bus
);
  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_t;
  state_t st, st_nx;
  logic [2:0] cnt [32];
  logic [31:0] stall_cnt;
  logic hazard, issue;
  always_comb begin
    hazard = !rst && bus.id_valid &&
             ((bus.id_rs_a_used && cnt[bus.id_rs_a] != 3'd0) ||
              (bus.id_rs_b_used && cnt[bus.id_rs_b] != 3'd0));
    issue = !rst && bus.id_valid && !hazard && !bus.ex_redirect;
    bus.ifd_flush = !rst && bus.ex_redirect;
    bus.de_bubble = !rst && (bus.ex_redirect || hazard);
    bus.pc_hold = hazard && !bus.ex_redirect;
    bus.ifd_hold = hazard && !bus.ex_redirect;
    st_nx = bus.ex_redirect ? FLUSH : hazard ? STALL : RUN;
    bus.state = st;
    bus.stall_cycles = stall_cnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= RUN;
      stall_cnt <= '0;
    end else begin
      st <= st_nx;
      if (bus.pc_hold && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
    end
  end
  // a WAW reload on issue takes precedence over the entry's own decrement
  always_ff @(posedge clk) begin
    for (int i = 0; i < 32; i++) begin
      if (rst) cnt[i] <= 3'd0;
      else if (issue && bus.id_wr_en && bus.id_wr_dir == 5'(i)) cnt[i] <= 3'(WB_LAT);
      else if (cnt[i] != 3'd0) cnt[i] <= cnt[i] - 3'd1;
    end
  end
endmodule

// File: tb/tb_hazard_sched.sv
// tb_hazard_sched: directed per-cycle vectors with hand-computed expectations checked by a scoreboard monitor
module tb_hazard_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  hazard_sched_if bus ();
  hazard_sched #(.WB_LAT(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {
    int          cyc;
    logic [3:0]  ctrl;
    logic [1:0]  st;
    logic [31:0] sc;
  } exp_t;
  exp_t q [$];
  initial begin
    bus.id_valid = 0; bus.id_rs_a = 0; bus.id_rs_a_used = 0; bus.id_rs_b = 0;
    bus.id_rs_b_used = 0; bus.id_wr_en = 0; bus.id_wr_dir = 0; bus.ex_redirect = 0;
  end
  // ctrl = {pc_hold, ifd_hold, ifd_flush, de_bubble}
  task automatic cyc(input int n, input logic r, input logic v, input logic [4:0] a, input logic au,
                     input logic [4:0] b, input logic bu, input logic we, input logic [4:0] wd,
                     input logic rd, input logic [3:0] ec, input logic [1:0] es, input logic [31:0] esc);
    @(posedge clk);
    #1;
    rst = r; bus.id_valid = v; bus.id_rs_a = a; bus.id_rs_a_used = au; bus.id_rs_b = b;
    bus.id_rs_b_used = bu; bus.id_wr_en = we; bus.id_wr_dir = wd; bus.ex_redirect = rd;
    q.push_back('{cyc: n, ctrl: ec, st: es, sc: esc});
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      automatic exp_t e = q.pop_front();
      automatic logic [3:0] c = {bus.pc_hold, bus.ifd_hold, bus.ifd_flush, bus.de_bubble};
      checks += 3;
      if (c !== e.ctrl) begin
        errors++;
        $display("FAIL ctrl c%0d: got %b expected %b", e.cyc, c, e.ctrl);
      end
      if (bus.state !== e.st) begin
        errors++;
        $display("FAIL state c%0d: got %0d expected %0d", e.cyc, bus.state, e.st);
      end
      if (bus.stall_cycles !== e.sc) begin
        errors++;
        $display("FAIL stall_cycles c%0d: got %0d expected %0d", e.cyc, bus.stall_cycles, e.sc);
      end
    end
  end
  initial begin
    //   n  rst v  a  au b  bu we wd rd  ctrl     st sc
    cyc( 0, 1, 1, 4, 1, 0, 0, 1, 4, 1, 4'b0000, 0, 0);
    cyc( 1, 0, 1,10, 1, 0, 0, 1, 1, 0, 4'b0000, 0, 0);
    cyc( 2, 0, 1,11, 1,12, 1, 1, 2, 0, 4'b0000, 0, 0);
    cyc( 3, 0, 1,13, 1, 0, 0, 1, 3, 0, 4'b0000, 0, 0);
    cyc( 4, 0, 0, 3, 1, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
    cyc( 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
    cyc( 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
    cyc( 7, 0, 1, 0, 0, 0, 0, 1, 5, 0, 4'b0000, 0, 0);
    cyc( 8, 0, 1, 5, 1, 0, 0, 1, 6, 0, 4'b1101, 0, 0);
    cyc( 9, 0, 1, 5, 1, 0, 0, 1, 6, 0, 4'b1101, 1, 1);
    cyc(10, 0, 1, 5, 1, 0, 0, 1, 6, 0, 4'b1101, 1, 2);
    cyc(11, 0, 1, 5, 1, 0, 0, 1, 6, 0, 4'b0000, 1, 3);
    cyc(12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 3);
    cyc(13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 3);
    cyc(14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 3);
    cyc(15, 0, 1, 0, 0, 0, 0, 1, 7, 0, 4'b0000, 0, 3);
    cyc(16, 0, 1, 0, 0, 0, 0, 1, 7, 0, 4'b0000, 0, 3);
    cyc(17, 0, 1, 7, 1, 0, 0, 0, 0, 0, 4'b1101, 0, 3);
    cyc(18, 0, 1, 7, 1, 0, 0, 0, 0, 0, 4'b1101, 1, 4);
    cyc(19, 0, 1, 7, 1, 0, 0, 0, 0, 0, 4'b1101, 1, 5);
    cyc(20, 0, 1, 7, 1, 0, 0, 0, 0, 0, 4'b0000, 1, 6);
    cyc(21, 0, 1, 0, 0, 0, 0, 1, 8, 0, 4'b0000, 0, 6);
    cyc(22, 0, 1, 8, 1, 0, 0, 0, 0, 0, 4'b1101, 0, 6);
    cyc(23, 0, 1, 8, 1, 0, 0, 1, 9, 1, 4'b0011, 1, 7);
    cyc(24, 0, 1, 8, 1, 0, 0, 0, 0, 0, 4'b1101, 2, 7);
    cyc(25, 0, 1, 8, 1, 0, 0, 1, 9, 0, 4'b0000, 1, 8);
    cyc(26, 0, 1, 0, 0, 9, 0, 0, 0, 0, 4'b0000, 0, 8);
    cyc(27, 0, 1,20, 1, 0, 0, 1,20, 0, 4'b0000, 0, 8);
    cyc(28, 0, 1, 0, 0, 0, 0, 1, 4, 0, 4'b0000, 0, 8);
    cyc(29, 0, 1, 4, 1, 0, 0, 0, 0, 0, 4'b1101, 0, 8);
    cyc(30, 1, 1, 4, 1, 0, 0, 0, 0, 0, 4'b0000, 1, 9);
    cyc(31, 0, 1, 4, 1,20, 1, 0, 0, 0, 4'b0000, 0, 0);
    cyc(32, 0, 1, 0, 0, 0, 0, 1, 0, 0, 4'b0000, 0, 0);
    cyc(33, 0, 1, 0, 1, 0, 0, 0, 0, 0, 4'b1101, 0, 0);
    cyc(34, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 1);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hazard_sched.md
# hazard_sched

Pipeline hazard scheduler for the five-stage 32-bit core (IF, ID, EX, MEM, WB). It tracks in-flight register writes in a per-register countdown scoreboard and holds PC and PipeIFD while an ID-stage instruction reads a pending register. It inserts bubbles into PipeDE and flushes PipeIFD/PipeDE when EX resolves a taken PC redirect. It sits beside ControlUnit and drives the enables and clears of PC, PipeIFD and PipeDE.

## Interface
- WB_LAT, 3, cycles from the ID→EX issue edge until the register-bank write is visible to an ID read (2..7)
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- id_valid  in  1  PipeIFD holds a real instruction
- id_rs_a  in  5  source A register address (DirRegAIFDOUT)
- id_rs_a_used  in  1  source A is read by this opcode
- id_rs_b  in  5  source B address after the DirRegB mux
- id_rs_b_used  in  1  source B is read by this opcode
- id_wr_en  in  1  instruction writes a register (decoded WriteReg)
- id_wr_dir  in  5  final destination register, including the forced-25 case
- ex_redirect  in  1  EX selects a non-sequential PC this cycle
- pc_hold  out  1  PC keeps its value
- ifd_hold  out  1  PipeIFD keeps its value
- ifd_flush  out  1  PipeIFD loads a NOP
- de_bubble  out  1  PipeDE loads a NOP (WriteReg=0, WriteMem=0)
- state  out  2  0=RUN, 1=STALL, 2=FLUSH
- stall_cycles  out  32  saturating count of cycles with pc_hold=1

## Operation
- Scoreboard: 32 entries, each a 3-bit down-counter cnt[r]. Register r is busy while cnt[r]≠0. Every nonzero entry decrements by 1 each cycle.
- Hazard (combinational): id_valid & ((id_rs_a_used & busy[id_rs_a]) | (id_rs_b_used & busy[id_rs_b])).
- Issue: id_valid & !hazard & !ex_redirect. On an issue edge with id_wr_en=1, cnt[id_wr_dir] loads WB_LAT. This load overrides the decrement of that entry (WAW reload). A non-issuing cycle loads nothing.
- Redirect has priority over hazard. With ex_redirect=1: ifd_flush=1, de_bubble=1, pc_hold=0, ifd_hold=0, and no scoreboard load.
- Hazard without redirect: pc_hold=1, ifd_hold=1, de_bubble=1, ifd_flush=0.
- Otherwise all four control outputs are 0.
- FSM, next-state evaluated each edge:
  - any state → FLUSH if ex_redirect
  - else → STALL if hazard
  - else → RUN
  - FLUSH lasts exactly one cycle unless ex_redirect is reasserted.
- The state output is registered and reflects the previous cycle's decision. Control outputs are combinational from the current inputs and scoreboard.
- stall_cycles increments on every edge where pc_hold=1 and saturates at 0xFFFFFFFF.
- All 32 registers are tracked, including 0 and 25.

## Timing
- Reset, synchronous:
  - every cnt[r]=0, state=RUN, stall_cycles=0
  - pc_hold, ifd_hold, ifd_flush, de_bubble=0 while rst=1, regardless of inputs
  - no scoreboard load while rst=1.
- Reset asserted mid-stall clears all pending entries. The next instruction issues immediately after rst deasserts.
- Dependency latency: a producer issues at edge E0. A consumer in ID is held during cycles E0+1..E0+WB_LAT and issues at edge E0+WB_LAT+1. With WB_LAT=3 this is exactly 3 stall cycles for a back-to-back dependency.
- Independent instruction: zero stall cycles.
- A consumer of the same register that is reading and being written by itself (rs=rd): checked against the old cnt, before its own load.
- Redirect: takes effect at the edge ending the redirect cycle. The next cycle PipeIFD and PipeDE hold NOPs and state=FLUSH.
- Redirect and hazard in the same cycle: the flush wins. stall_cycles does not increment.

## Test plan
- Independent stream: issue r1←, r2←, r3← with no shared sources → pc_hold never 1, stall_cycles=0, state stays RUN.
- RAW back-to-back: write r5, next instruction reads r5 on A with WB_LAT=3 → pc_hold=1 for exactly 3 cycles, state=STALL in those cycles, consumer issues on the 4th, stall_cycles=3.
- WAW reload: write r7 at E0 and again at E0+1, then read r7 → stall continues until cnt from the second load expires (4 cycles total from E0+1 to issue).
- Redirect during stall: a hazard is active and ex_redirect=1 → ifd_flush=1, de_bubble=1, pc_hold=0, state=FLUSH next cycle, stall_cycles unchanged that cycle.
- Unused operand: busy r9 with id_rs_b=9 and id_rs_b_used=0 → no stall.
- Reset mid-operation: rst=1 for one cycle while cnt[r4]=2 → all outputs 0, stall_cycles=0, and a reader of r4 issues the cycle after rst deasserts.
